// File: rtl/adc4xmt.sv
// Parallel-side transmitter for the 4-channel, 12-bit, two-lane ADC stream.
// Generates samples, splits them onto 6-bit lanes, adds the frame word and applies bit misalignment.
module adc4xmt (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  MODE,
    input  logic [47:0] SAMPLE,
    input  logic        SVALID,
    input  logic [11:0] PATTERN,
    input  logic        slip,
    input  logic        slip_clr,
    input  logic        cnt_reset,
    output logic [47:0] DOUT,
    output logic [5:0]  FROUT,
    output logic [2:0]  slip_ofs,
    output logic [15:0] sent_cnt
);

    localparam logic [5:0]  FRAME      = 6'b111000;
    localparam logic [1:0]  MODE_PASS  = 2'd0;
    localparam logic [1:0]  MODE_RAMP  = 2'd1;
    localparam logic [1:0]  MODE_FIXED = 2'd2;
    localparam logic [1:0]  MODE_PRBS  = 2'd3;
    localparam logic [14:0] PRBS_SEED  = 15'h7FFF;
    localparam logic [2:0]  OFS_MAX    = 3'd5;
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    logic [47:0] s_q, s_d;
    logic [11:0] ramp_q, ramp_d;
    logic [14:0] prbs_q, prbs_d;
    logic [2:0]  ofs_q, ofs_d;
    logic [15:0] cnt_q, cnt_d;
    logic [47:0] prev_q, prev_d;
    logic [47:0] dout_q, dout_d;
    logic        frame_on_q, frame_on_d;
    logic [5:0]  frame_prev_q, frame_prev_d;
    logic [5:0]  frout_q, frout_d;
    logic [5:0]  frame_cur;
    logic        load;

    // Output word = {prev, cur}[5+s:s]; each unit of s delays the serial stream by one bit.
    function automatic logic [5:0] rotate(input logic [5:0] p, input logic [5:0] c,
                                          input logic [2:0] s);
        logic [11:0] cat;
        cat = {p, c} >> s;
        return cat[5:0];
    endfunction

    assign load = (MODE != MODE_PASS) || SVALID;

    // Stage 1: sample source select
    always_comb begin
        s_d = s_q;
        case (MODE)
            MODE_PASS: begin
                if (SVALID) s_d = SAMPLE;
            end
            MODE_RAMP: begin
                for (int k = 0; k < 4; k++) begin
                    s_d[12*k +: 12] = ramp_q + {k[1:0], 10'd0};
                end
            end
            MODE_FIXED: begin
                s_d = {4{PATTERN}};
            end
            MODE_PRBS: begin
                for (int k = 0; k < 4; k++) begin
                    s_d[12*k +: 12] = prbs_q[k +: 12];
                end
            end
            default: s_d = s_q;
        endcase
    end

    // Ramp and PRBS only run while their mode is selected, otherwise they sit at their start value.
    always_comb begin
        ramp_d = (MODE == MODE_RAMP) ? ramp_q + 12'd1 : 12'd0;
        prbs_d = (MODE == MODE_PRBS) ? {prbs_q[13:0], prbs_q[14] ^ prbs_q[13]} : PRBS_SEED;
    end

    // Stage 2: continuous rotation of every lane and the frame lane
    always_comb begin
        frame_cur    = frame_on_q ? FRAME : 6'd0;
        frame_on_d   = 1'b1;
        prev_d       = s_q;
        frame_prev_d = frame_cur;
        dout_d       = '0;
        for (int i = 0; i < 8; i++) begin
            dout_d[6*i +: 6] = rotate(prev_q[6*i +: 6], s_q[6*i +: 6], ofs_q);
        end
        frout_d = rotate(frame_prev_q, frame_cur, ofs_q);
    end

    always_comb begin
        ofs_d = ofs_q;
        if (slip_clr) begin
            ofs_d = 3'd0;
        end else if (slip) begin
            ofs_d = (ofs_q == OFS_MAX) ? 3'd0 : ofs_q + 3'd1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_reset) begin
            cnt_d = 16'd0;
        end else if (load && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s_q          <= '0;
            ramp_q       <= '0;
            prbs_q       <= PRBS_SEED;
            ofs_q        <= '0;
            cnt_q        <= '0;
            prev_q       <= '0;
            dout_q       <= '0;
            frame_on_q   <= 1'b0;
            frame_prev_q <= '0;
            frout_q      <= '0;
        end else begin
            s_q          <= s_d;
            ramp_q       <= ramp_d;
            prbs_q       <= prbs_d;
            ofs_q        <= ofs_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            dout_q       <= dout_d;
            frame_on_q   <= frame_on_d;
            frame_prev_q <= frame_prev_d;
            frout_q      <= frout_d;
        end
    end

    assign DOUT     = dout_q;
    assign FROUT    = frout_q;
    assign slip_ofs = ofs_q;
    assign sent_cnt = cnt_q;

endmodule

// File: tb/tb_adc4xmt.sv
// Randomized bench for adc4xmt against a serial-stream reference model plus directed scenarios.
module tb_adc4xmt;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  MODE;
  logic [47:0] SAMPLE;
  logic        SVALID;
  logic [11:0] PATTERN;
  logic        slip;
  logic        slip_clr;
  logic        cnt_reset;
  logic [47:0] DOUT;
  logic [5:0]  FROUT;
  logic [2:0]  slip_ofs;
  logic [15:0] sent_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state (values after the most recent edge)
  logic [47:0] s_m;
  int          ramp_m;
  int          prbs_m;
  int          ofs_m;
  int          cnt_m;
  logic [5:0]  w_prev_m[9];
  logic [5:0]  w_cur_m[9];
  logic [47:0] dout_m;
  logic [5:0]  frout_m;

  adc4xmt dut (
    .CLK(CLK), .RST(RST), .MODE(MODE), .SAMPLE(SAMPLE), .SVALID(SVALID),
    .PATTERN(PATTERN), .slip(slip), .slip_clr(slip_clr), .cnt_reset(cnt_reset),
    .DOUT(DOUT), .FROUT(FROUT), .slip_ofs(slip_ofs), .sent_cnt(sent_cnt)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // serial view: window = prev word then cur word, bit 5 first; output is the window delayed by s bits
  function automatic logic [5:0] serial_delay(input logic [5:0] prev_w, input logic [5:0] cur_w,
                                              input int s);
    logic [5:0] r;
    int q;
    r = '0;
    for (int j = 0; j < 6; j++) begin
      q = 6 + j - s;
      if (q < 6) r[5-j] = prev_w[5-q];
      else       r[5-j] = cur_w[11-q];
    end
    return r;
  endfunction

  task automatic model_edge();
    int nb;
    logic ld;
    if (RST) begin
      s_m = '0; ramp_m = 0; prbs_m = 'h7FFF; ofs_m = 0; cnt_m = 0;
      dout_m = '0; frout_m = '0;
      for (int i = 0; i < 9; i++) begin w_prev_m[i] = '0; w_cur_m[i] = '0; end
    end else begin
      for (int i = 0; i < 8; i++) dout_m[6*i +: 6] = serial_delay(w_prev_m[i], w_cur_m[i], ofs_m);
      frout_m = serial_delay(w_prev_m[8], w_cur_m[8], ofs_m);
      ld = (MODE != 2'd0) || SVALID;
      case (MODE)
        2'd0: if (SVALID) s_m = SAMPLE;
        2'd1: for (int k = 0; k < 4; k++) s_m[12*k +: 12] = 12'((ramp_m + 1024 * k) % 4096);
        2'd2: for (int k = 0; k < 4; k++) s_m[12*k +: 12] = PATTERN;
        default: for (int k = 0; k < 4; k++) s_m[12*k +: 12] = 12'((prbs_m >> k) % 4096);
      endcase
      ramp_m = (MODE == 2'd1) ? (ramp_m + 1) % 4096 : 0;
      if (MODE == 2'd3) begin
        nb = ((prbs_m >> 14) ^ (prbs_m >> 13)) & 1;
        prbs_m = ((prbs_m << 1) | nb) % 32768;
      end else begin
        prbs_m = 'h7FFF;
      end
      // lane 2k = channel k LSBs, lane 2k+1 = channel k MSBs
      for (int k = 0; k < 4; k++) begin
        w_prev_m[2*k]   = w_cur_m[2*k];
        w_prev_m[2*k+1] = w_cur_m[2*k+1];
        w_cur_m[2*k]    = 6'(s_m[12*k +: 12] % 64);
        w_cur_m[2*k+1]  = 6'(s_m[12*k +: 12] / 64);
      end
      w_prev_m[8] = w_cur_m[8];
      w_cur_m[8]  = 6'b111000;
      if (slip_clr)  ofs_m = 0;
      else if (slip) ofs_m = (ofs_m + 1) % 6;
      if (cnt_reset)                 cnt_m = 0;
      else if (ld && cnt_m < 65535) cnt_m = cnt_m + 1;
    end
  endtask

  // driver: one clock, model update at the edge, compare 1 time unit later
  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check("dout", 64'(DOUT), 64'(dout_m));
    check("frout", 64'(FROUT), 64'(frout_m));
    check("slip_ofs", 64'(slip_ofs), 64'(ofs_m));
    check("sent_cnt", 64'(sent_cnt), 64'(cnt_m));
  endtask

  task automatic randomize_inputs();
    if ($urandom_range(0, 31) == 0) MODE = 2'($urandom_range(0, 3));
    SAMPLE    = {16'($urandom), $urandom};
    SVALID    = ($urandom_range(0, 2) == 0);
    if ($urandom_range(0, 15) == 0) PATTERN = 12'($urandom);
    slip      = ($urandom_range(0, 7) == 0);
    slip_clr  = ($urandom_range(0, 31) == 0);
    cnt_reset = ($urandom_range(0, 63) == 0);
  endtask

  task automatic clear_strobes();
    slip = 1'b0; slip_clr = 1'b0; cnt_reset = 1'b0; SVALID = 1'b0;
  endtask

  initial begin
    logic [11:0] last_ch0;
    int wraps;
    RST = 1'b1; MODE = 2'd0; SAMPLE = '0; PATTERN = '0;
    clear_strobes();
    repeat (2) tick();
    check("rst_dout", 64'(DOUT), 64'd0);
    check("rst_frout", 64'(FROUT), 64'd0);
    check("rst_cnt", 64'(sent_cnt), 64'd0);

    // fixed pattern from reset release
    MODE = 2'd2; PATTERN = 12'hA5C; RST = 1'b0;
    tick();
    check("frout_edge1", 64'(FROUT), 64'd0);
    tick();
    check("frout_edge2", 64'(FROUT), 64'(6'b111000));
    check("pattern_lanes", 64'(DOUT), 64'h0000_A5CA5CA5CA5C);
    check("pattern_cnt", 64'(sent_cnt), 64'd2);
    tick();
    check("pattern_cnt_inc", 64'(sent_cnt), 64'd3);

    // slips on a steady frame
    slip = 1'b1; tick(); slip = 1'b0;
    check("slip1_ofs", 64'(slip_ofs), 64'd1);
    tick();
    check("slip1_frout", 64'(FROUT), 64'(6'b011100));
    slip = 1'b1; tick(); slip = 1'b0; tick();
    check("slip2_frout", 64'(FROUT), 64'(6'b001110));
    slip = 1'b1; repeat (4) tick(); slip = 1'b0;
    check("slip6_ofs", 64'(slip_ofs), 64'd0);
    tick();
    check("slip6_frout", 64'(FROUT), 64'(6'b111000));
    slip = 1'b1; repeat (2) tick();
    slip_clr = 1'b1; tick(); clear_strobes();
    check("slip_clr_wins", 64'(slip_ofs), 64'd0);

    // single pass-through sample that then repeats
    MODE = 2'd0; cnt_reset = 1'b1; tick(); cnt_reset = 1'b0;
    SAMPLE = 48'h0000_0000_0FFF; SVALID = 1'b1; tick(); SVALID = 1'b0;
    for (int i = 0; i < 6; i++) begin
      SAMPLE = {16'($urandom), $urandom};
      tick();
      check("hold_ch0", 64'(DOUT[11:0]), 64'hFFF);
      check("hold_rest", 64'(DOUT[47:12]), 64'd0);
      check("hold_cnt", 64'(sent_cnt), 64'd1);
    end

    // ramp over a full wrap
    MODE = 2'd1; tick(); tick();
    check("ramp_ch3_msb", 64'(DOUT[47:42]), 64'(6'b110000));
    last_ch0 = DOUT[11:0];
    wraps = 0;
    for (int i = 0; i < 4098; i++) begin
      tick();
      if (last_ch0 == 12'hFFF && DOUT[11:0] == 12'h000) wraps++;
      last_ch0 = DOUT[11:0];
    end
    check("ramp_wraps", 64'(wraps), 64'd1);

    // PRBS with random slips, then fully random traffic
    MODE = 2'd3;
    for (int i = 0; i < 300; i++) begin
      slip = ($urandom_range(0, 7) == 0);
      tick();
    end
    clear_strobes();
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      tick();
    end
    clear_strobes();

    // counter saturation and reset priority
    MODE = 2'd2; cnt_reset = 1'b1; tick(); cnt_reset = 1'b0;
    repeat (65535) tick();
    check("cnt_sat", 64'(sent_cnt), 64'hFFFF);
    repeat (3) tick();
    check("cnt_sat_hold", 64'(sent_cnt), 64'hFFFF);
    cnt_reset = 1'b1; tick(); cnt_reset = 1'b0;
    check("cnt_reset_prio", 64'(sent_cnt), 64'd0);

    // reset mid-stream
    MODE = 2'd3; slip = 1'b1; repeat (3) tick(); slip = 1'b0; repeat (5) tick();
    RST = 1'b1; slip = 1'b1; cnt_reset = 1'b0; tick(); clear_strobes();
    check("mid_rst_dout", 64'(DOUT), 64'd0);
    check("mid_rst_frout", 64'(FROUT), 64'd0);
    check("mid_rst_ofs", 64'(slip_ofs), 64'd0);
    check("mid_rst_cnt", 64'(sent_cnt), 64'd0);
    RST = 1'b0;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc4xmt.md
# adc4xmt

Parallel-side transmitter that emits the 4-channel, 12-bit, two-lane, bytewise, x1-frame ADC stream in the same 6-bit-per-lane-per-CLK format the ADC receiver delivers after deserialization. It feeds OSERDES2 primitives, driven by the same CLK/IOCE domain, for loopback self-test, and it serves as a bench source for the receiver. The block generates samples (pass-through, ramp, fixed, PRBS), splits them onto lanes, appends the frame word 111000, and injects programmable bit misalignment so the receiver's bitslip loop can be exercised.

## Interface
- FRAME, 6'b111000, frame word per CLK (bit 5 is the first serial bit)
- CLK  in  1  global clock; all logic is on its rising edge
- RST  in  1  synchronous, active-high reset
- MODE  in  2  sample source: 0 = SAMPLE input, 1 = ramp, 2 = fixed PATTERN, 3 = PRBS-15
- SAMPLE  in  48  channel k = SAMPLE[12k+11:12k], used in mode 0
- SVALID  in  1  SAMPLE valid strobe, mode 0 only
- PATTERN  in  12  fixed value for mode 2
- slip  in  1  one-cycle strobe; increments the bit offset
- slip_clr  in  1  forces the bit offset to 0
- cnt_reset  in  1  clears sent_cnt
- DOUT  out  48  lane words; lane i = DOUT[6i+5:6i], bit 5 first serial
- FROUT  out  6  frame lane word
- slip_ofs  out  3  current bit offset, 0..5
- sent_cnt  out  16  samples loaded, saturating

## Operation
- Stage 1 (sample select, register S[47:0]):
  - Mode 0: load SAMPLE when SVALID=1; otherwise hold S. The stream never stops, so a held sample repeats.
  - Mode 1: channel k = (ramp + 0x400·k) mod 4096. The 12-bit ramp counter increments every cycle and is held at 0 whenever MODE≠1.
  - Mode 2: every channel = PATTERN.
  - Mode 3: channel k = prbs[11+k:k]. prbs is a 15-bit LFSR, x^15+x^14+1, advancing one step per CLK, seeded to 15'h7FFF whenever MODE≠3.
- Lane split: for channel k, lane 2k+1 word = S[12k+11:12k+6] (MSBs), and lane 2k word = S[12k+5:12k].
- Stage 2 (rotation):
  - For each lane and for the frame, keep the previous unrotated word P and the current word C.
  - Form cat = {P,C}; the output word = cat[5+s:s], where s = slip_ofs.
  - s=0 gives C unchanged. Each unit of s delays the serial stream by one bit.
  - Example: frame with s=1 yields 011100.
- Offset control: slip_clr → s=0. Otherwise slip → s = (s==5) ? 0 : s+1. slip_clr wins over slip in the same cycle. The 5→0 wrap advances the stream by 5 bits, which is acceptable.
- sent_cnt increments on each stage-1 load: every cycle in modes 1–3, SVALID cycles in mode 0. It saturates at 16'hFFFF. cnt_reset clears it and has priority over an increment in the same cycle.
- Reset values: S, P, DOUT, FROUT, ramp = 0; prbs = 15'h7FFF; slip_ofs = 0; sent_cnt = 0. RST overrides slip, slip_clr and cnt_reset.

## Timing
- Latency from SAMPLE/SVALID to DOUT at s=0: 2 CLK (stage 1 register, then stage 2 register).
- A MODE change affects S on the next edge and DOUT one cycle later.
- slip sampled at edge n: slip_ofs updates at edge n, and rotated words appear at edge n+1.
- FROUT first equals FRAME at the second edge after RST is released. Before that it reads 0.
- P and C update every cycle regardless of mode or SVALID. The rotation is therefore continuous across mode changes and holds.
- Changing s mid-stream applies the new offset to the next word only; no words are dropped or repeated on lanes apart from the bit shift.

## Test plan
- Reset, MODE=2, PATTERN=12'hA5C, s=0 → from cycle 2: FROUT=111000; DOUT lanes odd=101001 and even=011100; sent_cnt increments by 1 per cycle.
- MODE=0, SVALID pulsed once with channel 0 = 12'hFFF and others 0, then held low → lanes 1:0 = 111111 from 2 cycles later and persisting; sent_cnt=1.
- MODE=1 for 4100 cycles → channel 3 MSB lane starts at 110000; the ramp wraps 0xFFF→0x000 exactly once.
- s=0, FRAME steady; apply 1, 2 and 6 slip pulses → FROUT = 011100, 001110, and back to 111000 (wrap). slip_clr together with slip → slip_ofs=0.
- Loopback into the receiver with BSENABLE=1 after 3 slips → the receiver realigns to FRAME and its bs_cnt stops incrementing. In MODE=3, the received samples match a reference LFSR seeded 7FFF.
- sent_cnt at 16'hFFFF with continuous loads → holds FFFF; cnt_reset and a load in the same cycle → 0; RST mid-stream → all outputs 0 on the next edge.
